// File: rtl/hex_scroll_display.sv
// Board-level hex message display: keys (synchronised + debounced) drive a
// load/scroll/pause FSM over a MSG_LEN-digit buffer shown through a NUM_DIGITS window.
module hex_scroll_display #(
  parameter int NUM_DIGITS = 6,
  parameter int MSG_LEN = 8,
  parameter logic [4*MSG_LEN-1:0] INIT_MSG = 32'h0823_0110,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int TICK_CYCLES = 25000000
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [7:0]              switch,
  input  logic [1:0]              key,
  output logic [9:0]              leds,
  output logic [8*NUM_DIGITS-1:0] hex
);

  localparam int PTR_W = (MSG_LEN > 1) ? $clog2(MSG_LEN) : 1;
  localparam int IDX_W = PTR_W + 1;
  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int PRE_W = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_CYCLES - 1);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(MSG_LEN - 1);

  typedef enum logic [1:0] {
    ST_LOAD   = 2'b00,
    ST_SCROLL = 2'b01,
    ST_PAUSE  = 2'b10
  } state_e;

  // Active-low segments, bit 0 = a ... bit 6 = g.
  function automatic logic [6:0] seg7(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'h0: s = 7'b1000000;
      4'h1: s = 7'b1111001;
      4'h2: s = 7'b0100100;
      4'h3: s = 7'b0110000;
      4'h4: s = 7'b0011001;
      4'h5: s = 7'b0010010;
      4'h6: s = 7'b0000010;
      4'h7: s = 7'b1111000;
      4'h8: s = 7'b0000000;
      4'h9: s = 7'b0010000;
      4'hA: s = 7'b0001000;
      4'hB: s = 7'b0000011;
      4'hC: s = 7'b1000110;
      4'hD: s = 7'b0100001;
      4'hE: s = 7'b0000110;
      default: s = 7'b0001110;
    endcase
    return s;
  endfunction

  logic [1:0]            sync1_q, sync2_q;
  logic [1:0]            deb_q, deb_d;
  logic [1:0]            press_q, press_d;
  logic [1:0][CNT_W-1:0] cnt_q, cnt_d;

  state_e           state_q, state_d;
  logic [PTR_W-1:0] wr_q, wr_d;
  logic [PTR_W-1:0] offset_q, offset_d;
  logic [PRE_W-1:0] presc_q, presc_d;
  logic [3:0]       msg_q [MSG_LEN];
  logic [3:0]       msg_d [MSG_LEN];
  logic [7:0]       leds_q;
  logic [PTR_W-1:0] wr_inc, offset_inc;

  // Debounce: the accepted level flips only after the synchronised level has
  // disagreed with it for DEBOUNCE_CYCLES consecutive cycles.
  always_comb begin
    deb_d   = deb_q;
    press_d = 2'b00;
    cnt_d   = '0;
    for (int k = 0; k < 2; k++) begin
      if (sync2_q[k] != deb_q[k]) begin
        if (cnt_q[k] == CNT_LAST) begin
          deb_d[k]   = sync2_q[k];
          press_d[k] = deb_q[k];
        end else begin
          cnt_d[k] = cnt_q[k] + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= 2'b11;
      sync2_q <= 2'b11;
      deb_q   <= 2'b11;
      press_q <= 2'b00;
      cnt_q   <= '0;
    end else begin
      sync1_q <= key;
      sync2_q <= sync1_q;
      deb_q   <= deb_d;
      press_q <= press_d;
      cnt_q   <= cnt_d;
    end
  end

  assign wr_inc     = (wr_q == PTR_LAST) ? '0 : wr_q + 1'b1;
  assign offset_inc = (offset_q == PTR_LAST) ? '0 : offset_q + 1'b1;

  // key1 is checked first everywhere so it wins over a coincident key0 event.
  always_comb begin
    state_d  = state_q;
    wr_d     = wr_q;
    offset_d = offset_q;
    presc_d  = presc_q;
    msg_d    = msg_q;
    case (state_q)
      ST_LOAD: begin
        if (press_q[1]) begin
          msg_d[wr_q] = switch[3:0];
          wr_d        = wr_inc;
        end else if (press_q[0]) begin
          state_d = ST_SCROLL;
          presc_d = '0;
        end
      end
      ST_SCROLL: begin
        if (press_q[1]) begin
          state_d  = ST_LOAD;
          wr_d     = '0;
          offset_d = '0;
          presc_d  = '0;
        end else if (press_q[0]) begin
          state_d = ST_PAUSE;
        end else if (presc_q == PRE_LAST) begin
          presc_d  = '0;
          offset_d = offset_inc;
        end else begin
          presc_d = presc_q + 1'b1;
        end
      end
      ST_PAUSE: begin
        if (press_q[1]) begin
          state_d  = ST_LOAD;
          wr_d     = '0;
          offset_d = '0;
          presc_d  = '0;
        end else if (press_q[0]) begin
          state_d = ST_SCROLL;
        end
      end
      default: state_d = ST_LOAD;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_LOAD;
      wr_q     <= '0;
      offset_q <= '0;
      presc_q  <= '0;
      leds_q   <= '0;
      for (int j = 0; j < MSG_LEN; j++) begin
        msg_q[j] <= INIT_MSG[4*(MSG_LEN-1-j) +: 4];
      end
    end else begin
      state_q  <= state_d;
      wr_q     <= wr_d;
      offset_q <= offset_d;
      presc_q  <= presc_d;
      leds_q   <= switch;
      msg_q    <= msg_d;
    end
  end

  assign leds = {state_q, leds_q};

  // Display g shows msg[(offset + REL) mod MSG_LEN]; REL < MSG_LEN keeps one subtract enough.
  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_disp
    localparam int REL = NUM_DIGITS - 1 - g;
    logic [IDX_W-1:0] sum;
    logic [PTR_W-1:0] idx;
    logic             dp_lit;
    assign sum    = {1'b0, offset_q} + IDX_W'(REL);
    assign idx    = (sum >= IDX_W'(MSG_LEN)) ? PTR_W'(sum - IDX_W'(MSG_LEN)) : PTR_W'(sum);
    assign dp_lit = (state_q == ST_LOAD) && (wr_q == PTR_W'(REL));
    assign hex[8*g +: 8] = {~dp_lit, seg7(msg_q[idx])};
  end

endmodule

// File: tb/tb_hex_scroll_display.sv
// Bench for hex_scroll_display: scenario tasks checked against a cycle-level
// behavioural model built from the display/key rules.
module tb_hex_scroll_display;

  localparam int D   = 4;
  localparam int TCK = 10;
  localparam int HL  = D + 2;

  logic        clk;
  logic        rst;
  logic [7:0]  switch;
  logic [1:0]  key;
  logic [9:0]  leds;
  logic [47:0] hex;

  int checks = 0;
  int failures = 0;

  hex_scroll_display #(
    .NUM_DIGITS(6),
    .MSG_LEN(8),
    .INIT_MSG(32'h0823_0110),
    .DEBOUNCE_CYCLES(D),
    .TICK_CYCLES(TCK)
  ) dut (
    .clk(clk),
    .rst(rst),
    .switch(switch),
    .key(key),
    .leds(leds),
    .hex(hex)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model state: 0 = LOAD, 1 = SCROLL, 2 = PAUSE.
  int         m_state, m_wr, m_off, m_presc;
  int         m_buf [8];
  logic [7:0] m_leds;
  bit         m_deb [2];
  bit         m_pend [2];
  bit         hist [2][HL];

  function automatic logic [6:0] seg_of(input int d);
    logic [6:0] lit;
    case (d)
      0: lit = 7'h3F;  1: lit = 7'h06;  2: lit = 7'h5B;  3: lit = 7'h4F;
      4: lit = 7'h66;  5: lit = 7'h6D;  6: lit = 7'h7D;  7: lit = 7'h07;
      8: lit = 7'h7F;  9: lit = 7'h6F;  10: lit = 7'h77; 11: lit = 7'h7C;
      12: lit = 7'h39; 13: lit = 7'h5E; 14: lit = 7'h79; default: lit = 7'h71;
    endcase
    return ~lit;
  endfunction

  function automatic void model_reset();
    m_state = 0; m_wr = 0; m_off = 0; m_presc = 0; m_leds = 8'h00;
    m_buf = '{0, 8, 2, 3, 0, 1, 1, 0};
    for (int k = 0; k < 2; k++) begin
      m_deb[k] = 1'b1;
      m_pend[k] = 1'b0;
      for (int j = 0; j < HL; j++) hist[k][j] = 1'b1;
    end
  endfunction

  // One rising edge: raw key history (pre-reset history counts as released),
  // a debounced flip once the synchronised samples of the last D cycles all disagree,
  // and the resulting press acted on one edge later.
  function automatic void model_edge();
    bit ev [2];
    bit all_new;
    for (int k = 0; k < 2; k++) begin
      ev[k] = m_pend[k];
      m_pend[k] = 1'b0;
      all_new = 1'b1;
      for (int j = 1; j <= D; j++) if (hist[k][j] == m_deb[k]) all_new = 1'b0;
      if (all_new) begin
        m_deb[k] = ~m_deb[k];
        m_pend[k] = ~m_deb[k];
      end
      for (int j = HL - 1; j > 0; j--) hist[k][j] = hist[k][j-1];
      hist[k][0] = key[k];
    end
    if (m_state == 0) begin
      if (ev[1]) begin
        m_buf[m_wr] = int'(switch[3:0]);
        m_wr = (m_wr + 1) % 8;
      end else if (ev[0]) begin
        m_state = 1; m_presc = 0;
      end
    end else if (ev[1]) begin
      m_state = 0; m_wr = 0; m_off = 0; m_presc = 0;
    end else if (m_state == 1) begin
      if (ev[0]) m_state = 2;
      else begin
        m_presc = m_presc + 1;
        if (m_presc == TCK) begin
          m_presc = 0;
          m_off = (m_off + 1) % 8;
        end
      end
    end else if (ev[0]) begin
      m_state = 1;
    end
    m_leds = switch;
  endfunction

  function automatic logic [47:0] exp_hex();
    logic [47:0] r;
    int idx;
    logic dp;
    for (int i = 0; i < 6; i++) begin
      idx = (m_off + 5 - i) % 8;
      dp = (m_state == 0) && (m_wr < 6) && (idx == m_wr);
      r[8*i +: 8] = {~dp, seg_of(m_buf[idx])};
    end
    return r;
  endfunction

  function automatic logic [9:0] exp_leds();
    logic [1:0] code;
    code = (m_state == 0) ? 2'b00 : (m_state == 1) ? 2'b01 : 2'b10;
    return {code, m_leds};
  endfunction

  // Reset message as displayed: 0,8,2,3,0,1 on displays 5..0, DP on display 5.
  function automatic logic [47:0] init_hex();
    return {1'b0, seg_of(0), 1'b1, seg_of(8), 1'b1, seg_of(2),
            1'b1, seg_of(3), 1'b1, seg_of(0), 1'b1, seg_of(1)};
  endfunction

  task automatic tick();
    @(posedge clk);
    if (rst) model_reset();
    else model_edge();
    @(negedge clk);
  endtask

  task automatic press(input logic [1:0] mask, input int hold, input int gap);
    key = ~mask;
    repeat (hold) tick();
    key = 2'b11;
    repeat (gap) tick();
  endtask

  task automatic sync_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    #1 rst = 1'b1;
    model_reset();
    tick();
    checks++;
    if (leds !== 10'b0) begin
      failures++; $display("FAIL reset_leds got=%h want=000", leds);
    end
    checks++;
    if (hex !== init_hex()) begin
      failures++; $display("FAIL reset_hex got=%h want=%h", hex, init_hex());
    end
    switch = 8'hA5;
    rst = 1'b0;
    tick();
    checks++;
    if (leds !== {2'b00, 8'hA5}) begin
      failures++; $display("FAIL leds_follow got=%h want=0a5", leds);
    end
  endtask

  task automatic test_debounce();
    press(2'b01, 3, 10);
    checks++;
    if (leds[9:8] !== 2'b00 || hex !== exp_hex()) begin
      failures++; $display("FAIL glitch_no_event mode=%b want=00 hex=%h want=%h", leds[9:8], hex, exp_hex());
    end
    key[0] = 1'b0;
    repeat (8) tick();
    checks++;
    if (leds[9:8] !== 2'b01) begin
      failures++; $display("FAIL press_event mode=%b want=01", leds[9:8]);
    end
    for (int c = 0; c < 100; c++) begin
      tick();
      checks++;
      if (hex !== exp_hex() || leds !== exp_leds()) begin
        failures++; $display("FAIL hold_cycle %0d hex=%h want=%h leds=%h want=%h", c, hex, exp_hex(), leds, exp_leds());
      end
    end
    checks++;
    if (leds[9:8] !== 2'b01) begin
      failures++; $display("FAIL held_single_event mode=%b want=01", leds[9:8]);
    end
    key[0] = 1'b1;
    repeat (10) tick();
    press(2'b10, 8, 8);
    checks++;
    if (leds[9:8] !== 2'b00 || hex !== init_hex()) begin
      failures++; $display("FAIL back_to_load mode=%b hex=%h want=%h", leds[9:8], hex, init_hex());
    end
  endtask

  task automatic test_load();
    switch = 8'h07;
    press(2'b10, 8, 8);
    switch = 8'h3E;
    press(2'b10, 8, 8);
    checks++;
    if (hex[46:40] !== seg_of(7) || hex[38:32] !== seg_of(14)) begin
      failures++; $display("FAIL load_digits got=%h_%h want=%h_%h", hex[46:40], hex[38:32], seg_of(7), seg_of(14));
    end
    checks++;
    if (hex[31] !== 1'b0 || hex[47] !== 1'b1 || hex[39] !== 1'b1) begin
      failures++; $display("FAIL load_dp got=%b%b%b want=110", hex[47], hex[39], hex[31]);
    end
    checks++;
    if (hex !== exp_hex()) begin
      failures++; $display("FAIL load_model hex=%h want=%h", hex, exp_hex());
    end
    for (int n = 0; n < 6; n++) begin
      switch = 8'($urandom);
      press(2'b10, 8, 8);
    end
    checks++;
    if (hex[47] !== 1'b0 || hex !== exp_hex()) begin
      failures++; $display("FAIL wrptr_wrap hex=%h want=%h", hex, exp_hex());
    end
  endtask

  task automatic test_scroll_wrap();
    logic [47:0] exp5;
    bit done, seen5;
    int c;
    sync_reset();
    key[0] = 1'b0;
    c = 0;
    while (m_state != 1 && c < 20) begin tick(); c++; end
    checks++;
    if (m_state != 1 || leds[9:8] !== 2'b01) begin
      failures++; $display("FAIL scroll_entry mode=%b want=01 waited=%0d", leds[9:8], c);
    end
    repeat (9) tick();
    checks++;
    if (hex[46:40] !== seg_of(0) || hex !== exp_hex()) begin
      failures++; $display("FAIL pre_first_step hex=%h want=%h", hex, exp_hex());
    end
    tick();
    checks++;
    if (hex[46:40] !== seg_of(8) || hex !== exp_hex()) begin
      failures++; $display("FAIL first_step hex=%h want=%h", hex, exp_hex());
    end
    key[0] = 1'b1;
    exp5 = {1'b1, seg_of(1), 1'b1, seg_of(1), 1'b1, seg_of(0),
            1'b1, seg_of(0), 1'b1, seg_of(8), 1'b1, seg_of(2)};
    done = 1'b0;
    seen5 = 1'b0;
    for (int k = 0; k < 100 && !done; k++) begin
      tick();
      checks++;
      if (hex !== exp_hex()) begin
        failures++; $display("FAIL scroll_cycle %0d hex=%h want=%h", k, hex, exp_hex());
      end
      if (m_off == 5 && !seen5) begin
        seen5 = 1'b1;
        checks++;
        if (hex !== exp5) begin
          failures++; $display("FAIL offset5_window hex=%h want=%h", hex, exp5);
        end
      end
      if (m_off == 0) done = 1'b1;
    end
    checks++;
    if (!done || !seen5 || hex[46:40] !== seg_of(0)) begin
      failures++; $display("FAIL offset_wrap done=%0d seen5=%0d left=%h want=%h", done, seen5, hex[46:40], seg_of(0));
    end
  endtask

  task automatic test_pause();
    logic [47:0] snap;
    int c, p;
    repeat (4) tick();
    key[0] = 1'b0;
    c = 0;
    while (m_state != 2 && c < 20) begin tick(); c++; end
    key[0] = 1'b1;
    checks++;
    if (leds[9:8] !== 2'b10 || hex !== exp_hex()) begin
      failures++; $display("FAIL pause_entry mode=%b want=10 hex=%h want=%h", leds[9:8], hex, exp_hex());
    end
    snap = hex;
    p = m_presc;
    for (int k = 0; k < 50; k++) begin
      tick();
      checks++;
      if (hex !== snap) begin
        failures++; $display("FAIL pause_frozen %0d hex=%h want=%h", k, hex, snap);
      end
    end
    key[0] = 1'b0;
    c = 0;
    while (m_state != 1 && c < 20) begin tick(); c++; end
    key[0] = 1'b1;
    checks++;
    if (leds[9:8] !== 2'b01) begin
      failures++; $display("FAIL resume mode=%b want=01", leds[9:8]);
    end
    repeat (TCK - p - 1) tick();
    checks++;
    if (hex !== snap) begin
      failures++; $display("FAIL resume_remaining hex=%h want=%h", hex, snap);
    end
    tick();
    checks++;
    if (hex !== exp_hex()) begin
      failures++; $display("FAIL resume_step hex=%h want=%h", hex, exp_hex());
    end
    repeat (3) tick();
    key = 2'b00;
    c = 0;
    while (m_state != 0 && c < 20) begin tick(); c++; end
    key = 2'b11;
    checks++;
    if (leds[9:8] !== 2'b00 || hex !== init_hex()) begin
      failures++; $display("FAIL simultaneous mode=%b want=00 hex=%h want=%h", leds[9:8], hex, init_hex());
    end
    repeat (10) tick();
    checks++;
    if (leds !== exp_leds() || hex !== exp_hex()) begin
      failures++; $display("FAIL after_simultaneous leds=%h want=%h hex=%h want=%h", leds, exp_leds(), hex, exp_hex());
    end
  endtask

  task automatic test_mid_reset();
    int c;
    sync_reset();
    switch = 8'h5C;
    press(2'b01, 8, 2);
    c = 0;
    while (m_off != 3 && c < 60) begin tick(); c++; end
    checks++;
    if (hex !== exp_hex()) begin
      failures++; $display("FAIL pre_reset_offset3 hex=%h want=%h", hex, exp_hex());
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if (leds !== 10'b0 || hex !== init_hex()) begin
      failures++; $display("FAIL async_reset_scroll leds=%h hex=%h want=%h", leds, hex, init_hex());
    end
    model_reset();
    tick();
    rst = 1'b0;
    tick();
    key[1] = 1'b0;
    repeat (3) tick();
    #2 rst = 1'b1;
    key = 2'b11;
    #1;
    checks++;
    if (leds !== 10'b0 || hex !== init_hex()) begin
      failures++; $display("FAIL async_reset_debounce leds=%h hex=%h want=%h", leds, hex, init_hex());
    end
    model_reset();
    tick();
    rst = 1'b0;
    for (int k = 0; k < 20; k++) begin
      tick();
      checks++;
      if (hex !== exp_hex() || leds !== exp_leds()) begin
        failures++; $display("FAIL post_reset_cycle %0d hex=%h want=%h leds=%h want=%h", k, hex, exp_hex(), leds, exp_leds());
      end
    end
    checks++;
    if (leds[9:8] !== 2'b00 || hex !== init_hex()) begin
      failures++; $display("FAIL no_spurious_event mode=%b hex=%h want=%h", leds[9:8], hex, init_hex());
    end
  endtask

  task automatic test_random();
    int hold, gap;
    logic [1:0] mask;
    for (int n = 0; n < 40; n++) begin
      mask = 2'($urandom_range(1, 3));
      hold = $urandom_range(1, 10);
      gap = $urandom_range(1, 10);
      switch = 8'($urandom);
      key = ~mask;
      for (int k = 0; k < hold + gap; k++) begin
        if (k == hold) key = 2'b11;
        tick();
        checks++;
        if (hex !== exp_hex() || leds !== exp_leds()) begin
          failures++; $display("FAIL random %0d.%0d hex=%h want=%h leds=%h want=%h", n, k, hex, exp_hex(), leds, exp_leds());
        end
      end
    end
  endtask

  initial begin
    rst = 1'b0;
    key = 2'b11;
    switch = 8'h00;
    model_reset();
    test_reset();
    test_debounce();
    test_load();
    test_scroll_wrap();
    test_pause();
    test_mid_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog expired");
  end

endmodule
